// File: rtl/mem_pkg.sv
// Shared types and constants for the parametrised data memory.
// FSM encoding, latency counter sizing and an index-width helper.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  localparam int MEM_LAT_MAX = 15;
  localparam int MEM_CNT_W   = 4;

  // Smallest w with 2**w >= n; returns 0 for n <= 1.
  function automatic int mem_idx_w(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// One byte lane of the word store: DEPTH bytes, single write port, async read.
// Every entry takes INIT_BYTE on synchronous reset.
module mem_byte_lane #(
  parameter int         DEPTH     = 64,
  parameter int         IDX_W     = 6,
  parameter logic [7:0] INIT_BYTE = 8'h00
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [7:0]       i_wdat,
  output logic [7:0]       o_rdat
);

  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= INIT_BYTE;
    end else if (i_we) begin
      r_mem[i_idx] <= i_wdat;
    end
  end

  assign o_rdat = r_mem[i_idx];

endmodule

// File: rtl/data_mem_param.sv
// MEM-stage data memory: word store with byte enables, programmable latency and req/hit handshake.
// hit pulses LATENCY cycles after acceptance; one access per LATENCY+1 cycles; out-of-range flags err.
module data_mem_param
  import mem_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 64,
  parameter int                LATENCY  = 2,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req,
  input  logic                 we,
  input  logic [DATA_W/8-1:0]  byteEn,
  input  logic [ADDR_W-1:0]    memAddress,
  input  logic [DATA_W-1:0]    writeData,
  output logic                 hit,
  output logic [DATA_W-1:0]    memOut,
  output logic                 err
);

  localparam int NB = DATA_W / 8;
  localparam int OB = mem_idx_w(NB);
  localparam int IW = mem_idx_w(DEPTH);
  localparam logic [MEM_CNT_W-1:0] LAT_INIT = MEM_CNT_W'(LATENCY - 1);
  localparam logic [MEM_CNT_W-1:0] CNT_ONE  = MEM_CNT_W'(1);
  localparam bit   LAT1 = (LATENCY == 1);

  mem_state_e           r_state;
  logic [MEM_CNT_W-1:0] r_cnt;
  logic                 r_we;
  logic [NB-1:0]        r_be;
  logic [IW-1:0]        r_idx;
  logic [DATA_W-1:0]    r_wdat;
  logic                 r_oor;
  logic                 r_hit;
  logic [DATA_W-1:0]    r_out;
  logic                 r_err;

  logic                 w_idle;
  logic [IW-1:0]        w_idx_in;
  logic                 w_oor_in;
  logic                 w_acc_we;
  logic [NB-1:0]        w_acc_be;
  logic [IW-1:0]        w_acc_idx;
  logic [DATA_W-1:0]    w_acc_wdat;
  logic                 w_acc_oor;
  logic                 w_commit;
  logic [DATA_W-1:0]    w_rdat;

  // Any address bit above the word index makes the access out of range.
  assign w_idx_in = memAddress[OB +: IW];
  assign w_oor_in = |(memAddress >> (OB + IW));
  assign w_idle   = (r_state == ST_IDLE);

  // With LATENCY==1 the access commits on the accepting edge, so live inputs are used.
  assign w_acc_we   = w_idle ? we        : r_we;
  assign w_acc_be   = w_idle ? byteEn    : r_be;
  assign w_acc_idx  = w_idle ? w_idx_in  : r_idx;
  assign w_acc_wdat = w_idle ? writeData : r_wdat;
  assign w_acc_oor  = w_idle ? w_oor_in  : r_oor;

  assign w_commit = (w_idle && req && LAT1) ||
                    ((r_state == ST_BUSY) && (r_cnt == CNT_ONE));

  for (genvar b = 0; b < NB; b++) begin : g_lane
    mem_byte_lane #(
      .DEPTH     (DEPTH),
      .IDX_W     (IW),
      .INIT_BYTE (INIT_VAL[8*b +: 8])
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .i_we   (w_commit && w_acc_we && w_acc_be[b] && !w_acc_oor),
      .i_idx  (w_acc_idx),
      .i_wdat (w_acc_wdat[8*b +: 8]),
      .o_rdat (w_rdat[8*b +: 8])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_be    <= '0;
      r_idx   <= '0;
      r_wdat  <= '0;
      r_oor   <= 1'b0;
      r_hit   <= 1'b0;
      r_out   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_hit <= 1'b0;
      r_out <= '0;
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req) begin
            r_we   <= we;
            r_be   <= byteEn;
            r_idx  <= w_idx_in;
            r_wdat <= writeData;
            r_oor  <= w_oor_in;
            if (LAT1) begin
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_BUSY;
              r_cnt   <= LAT_INIT;
            end
          end
        end
        ST_BUSY: begin
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) r_state <= ST_DONE;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
      if (w_commit) begin
        r_hit <= 1'b1;
        r_err <= w_acc_oor;
        r_out <= (!w_acc_we && !w_acc_oor) ? w_rdat : '0;
      end
    end
  end

  assign hit    = r_hit;
  assign memOut = r_out;
  assign err    = r_err;

endmodule

// File: tb/tb_data_mem_param.sv
// Bench for data_mem_param: directed and random accesses against an array model,
// plus a held-request latency sweep on LATENCY 1/3/7 instances.
module tb_data_mem_param;

  localparam int          DEPTH      = 64;
  localparam int          LAT_MAIN   = 2;
  localparam logic [31:0] SWEEP_INIT = 32'hA5A5_5A5A;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, we;
  logic [3:0]  byteEn;
  logic [31:0] memAddress, writeData;
  logic        hit, err;
  logic [31:0] memOut;

  logic        s_req, s_we;
  logic [3:0]  s_be;
  logic [31:0] s_addr, s_wd;
  logic [2:0]  s_hit, s_err;
  logic [31:0] s_out [3];

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] mdl [DEPTH];
  logic [31:0] got;
  logic [31:0] ra, rd;
  logic [3:0]  rbe;
  logic        rw, exp_hit;
  int          lat [3];
  int          nxt [3];

  always #5 clk = ~clk;

  data_mem_param #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .LATENCY(LAT_MAIN), .INIT_VAL(32'h0)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .byteEn(byteEn), .memAddress(memAddress),
    .writeData(writeData), .hit(hit), .memOut(memOut), .err(err));

  data_mem_param #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .LATENCY(1), .INIT_VAL(SWEEP_INIT)) u_l1 (
    .clk(clk), .reset(reset), .req(s_req), .we(s_we), .byteEn(s_be), .memAddress(s_addr),
    .writeData(s_wd), .hit(s_hit[0]), .memOut(s_out[0]), .err(s_err[0]));

  data_mem_param #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .LATENCY(3), .INIT_VAL(SWEEP_INIT)) u_l3 (
    .clk(clk), .reset(reset), .req(s_req), .we(s_we), .byteEn(s_be), .memAddress(s_addr),
    .writeData(s_wd), .hit(s_hit[1]), .memOut(s_out[1]), .err(s_err[1]));

  data_mem_param #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .LATENCY(7), .INIT_VAL(SWEEP_INIT)) u_l7 (
    .clk(clk), .reset(reset), .req(s_req), .we(s_we), .byteEn(s_be), .memAddress(s_addr),
    .writeData(s_wd), .hit(s_hit[2]), .memOut(s_out[2]), .err(s_err[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference behaviour: flat byte-addressed range, word array, lane-wise merge.
  task automatic model(input logic w, input logic [3:0] be, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] eo, output logic ee);
    int idx;
    if (a >= DEPTH * 4) begin
      eo = 32'h0;
      ee = 1'b1;
    end else begin
      idx = int'(a / 4);
      ee  = 1'b0;
      if (w) begin
        for (int b = 0; b < 4; b++) if (be[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
        eo = 32'h0;
      end else begin
        eo = mdl[idx];
      end
    end
  endtask

  task automatic access(input string tag, input logic w, input logic [3:0] be,
                        input logic [31:0] a, input logic [31:0] d, input bit drop_early,
                        output logic [31:0] obs);
    logic [31:0] eo;
    logic        ee;
    int          n;
    bit          seen;
    model(w, be, a, d, eo, ee);
    @(negedge clk);
    req = 1'b1; we = w; byteEn = be; memAddress = a; writeData = d;
    n = 0;
    seen = 1'b0;
    while (n < 20 && !seen) begin
      @(posedge clk); #1;
      n++;
      if (drop_early && n == 1) req = 1'b0;
      if (hit) seen = 1'b1;
    end
    check({tag, "_hit_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(n), 32'(LAT_MAIN));
    check({tag, "_memOut"}, memOut, eo);
    check({tag, "_err"}, 32'(err), 32'(ee));
    obs = memOut;
    req = 1'b0;
    @(posedge clk); #1;
    check({tag, "_hit_clear"}, 32'(hit), 32'd0);
    check({tag, "_out_clear"}, memOut, 32'd0);
  endtask

  initial begin
    reset = 1'b0; req = 1'b0; we = 1'b0; byteEn = '0; memAddress = '0; writeData = '0;
    s_req = 1'b0; s_we = 1'b0; s_be = '0; s_addr = '0; s_wd = '0;
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("rst_hit", 32'(hit), 32'd0);
    check("rst_memOut", memOut, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_sweep_hit", 32'(s_hit), 32'd0);

    access("rd_init_10", 1'b0, 4'h0, 32'h10, 32'h0, 1'b0, got);
    check("rd_init_10_val", got, 32'h0);
    access("wr_08", 1'b1, 4'hF, 32'h08, 32'hDEADBEEF, 1'b0, got);
    access("rd_08", 1'b0, 4'h0, 32'h08, 32'h0, 1'b0, got);
    check("rd_08_val", got, 32'hDEADBEEF);
    access("rd_0B", 1'b0, 4'h0, 32'h0B, 32'h0, 1'b0, got);
    check("rd_0B_val", got, 32'hDEADBEEF);
    access("wr_be5", 1'b1, 4'b0101, 32'h08, 32'h11223344, 1'b0, got);
    access("rd_be5", 1'b0, 4'h0, 32'h08, 32'h0, 1'b0, got);
    check("rd_be5_val", got, 32'hDE22BE44);
    access("wr_be0", 1'b1, 4'b0000, 32'h08, 32'hFFFFFFFF, 1'b0, got);
    access("rd_be0", 1'b0, 4'h0, 32'h08, 32'h0, 1'b0, got);
    check("rd_be0_val", got, 32'hDE22BE44);
    access("wr_00", 1'b1, 4'hF, 32'h00, 32'h12345678, 1'b0, got);
    access("rd_oor", 1'b0, 4'h0, 32'h100, 32'h0, 1'b0, got);
    access("wr_oor", 1'b1, 4'hF, 32'h100, 32'hAAAAAAAA, 1'b0, got);
    access("rd_00", 1'b0, 4'h0, 32'h00, 32'h0, 1'b0, got);
    check("rd_00_val", got, 32'h12345678);
    access("rd_hibit", 1'b0, 4'h0, 32'h80000008, 32'h0, 1'b0, got);
    access("rd_drop", 1'b0, 4'h0, 32'h08, 32'h0, 1'b1, got);
    check("rd_drop_val", got, 32'hDE22BE44);

    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 7))
        0:       ra = 32'h100 + 32'($urandom_range(0, 255));
        1:       ra = $urandom;
        2:       ra = 32'($urandom_range(0, 255));
        default: ra = 32'($urandom_range(0, 31));
      endcase
      rw  = 1'($urandom_range(0, 1));
      rbe = 4'($urandom);
      rd  = $urandom;
      access($sformatf("rnd%0d", t), rw, rbe, ra, rd, 1'b0, got);
    end

    lat = '{1, 3, 7};
    nxt = lat;
    @(negedge clk);
    s_addr = 32'($urandom_range(0, DEPTH - 1)) * 4;
    s_req  = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        exp_hit = (cyc == nxt[i]);
        check($sformatf("sweep_L%0d_c%0d_hit", lat[i], cyc), 32'(s_hit[i]), 32'(exp_hit));
        if (exp_hit) begin
          check($sformatf("sweep_L%0d_c%0d_out", lat[i], cyc), s_out[i], SWEEP_INIT);
          check($sformatf("sweep_L%0d_c%0d_err", lat[i], cyc), 32'(s_err[i]), 32'd0);
          nxt[i] = nxt[i] + lat[i] + 1;
        end
      end
    end
    @(negedge clk); s_req = 1'b0;

    // Abort a write while it is still in flight.
    @(negedge clk);
    req = 1'b1; we = 1'b1; byteEn = 4'hF; memAddress = 32'h04; writeData = 32'hCAFEF00D;
    @(posedge clk); #1;
    reset = 1'b0; req = 1'b0;
    @(posedge clk); #1;
    check("midrst_hit_during", 32'(hit), 32'd0);
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
    @(negedge clk); reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check($sformatf("midrst_hit_after%0d", c), 32'(hit), 32'd0);
      check($sformatf("midrst_sweep_hit%0d", c), 32'(s_hit), 32'd0);
    end
    access("rd_04_after_rst", 1'b0, 4'h0, 32'h04, 32'h0, 1'b0, got);
    check("rd_04_after_rst_val", got, 32'h0);
    access("rd_08_after_rst", 1'b0, 4'h0, 32'h08, 32'h0, 1'b0, got);
    check("rd_08_after_rst_val", got, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
